// File: rtl/sqrt_pkg.sv
// sqrt_pkg: constants and types shared by the square-root peripheral.
//   - register addresses for the chip-select/write-enable bus
//   - bit positions inside the STATUS/CTRL registers
//   - control FSM state encoding (also exported for observation)
package sqrt_pkg;

    localparam logic [1:0] ADDR_OPERAND = 2'd0;
    localparam logic [1:0] ADDR_REM     = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;

    localparam int DONE_BIT = 0;
    localparam int BUSY_BIT = 1;
    localparam int RND_BIT  = 2;
    localparam int IE_BIT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // nothing computed since reset
        ST_BUSY = 2'd1,   // iterating
        ST_DONE = 2'd2    // result valid in ROOT/REM
    } sqrt_state_e;

endpackage

// File: rtl/sqrt_unit_gen_if.sv
// sqrt_unit_gen_if: processor-side register bus of the square-root unit.
//   CS   chip select, access happens on a CLK edge when CS=1
//   WE   write enable, qualified by CS
//   ADDR register select
//   DI   write data
//   DO   read data (combinational, independent of CS)
//   DONE result valid
//   IRQ  one-cycle completion pulse
// Handshake: there is no back-pressure. A write takes effect on the rising
// edge where CS=1 and WE=1; reads are pure combinational decodes of ADDR and
// never have side effects.
interface sqrt_unit_gen_if #(
    parameter int WIDTH = 18
);
    logic             CS;
    logic             WE;
    logic [1:0]       ADDR;
    logic [WIDTH-1:0] DI;
    logic [WIDTH-1:0] DO;
    logic             DONE;
    logic             IRQ;

    modport master (
        output CS, WE, ADDR, DI,
        input  DO, DONE, IRQ
    );

    modport slave (
        input  CS, WE, ADDR, DI,
        output DO, DONE, IRQ
    );
endinterface

// File: rtl/sqrt_step.sv
// sqrt_step: one digit-by-digit square-root iteration (purely combinational).
//   i_rem   partial remainder, H+1 bits
//   i_root  partial root, H bits
//   i_bits  next two radicand bits (MSB first)
//   o_rem   next partial remainder
//   o_root  next partial root
module sqrt_step #(
    parameter int H = 9
) (
    input  logic [H:0]   i_rem,
    input  logic [H-1:0] i_root,
    input  logic [1:0]   i_bits,
    output logic [H:0]   o_rem,
    output logic [H-1:0] o_root
);
    // One extra bit of headroom so the trial subtraction sign is a plain compare.
    logic [H+2:0] w_acc;
    logic [H+2:0] w_sub;
    logic [H+2:0] w_diff;

    always_comb begin
        w_acc  = {i_rem, i_bits};
        w_sub  = {1'b0, i_root, 2'b01};
        w_diff = w_acc - w_sub;
        if (w_acc >= w_sub) begin
            o_rem  = (H+1)'(w_diff);
            o_root = H'({i_root, 1'b1});
        end else begin
            // The remainder never exceeds 2*root, so H+1 bits always hold it.
            o_rem  = (H+1)'(w_acc);
            o_root = H'({i_root, 1'b0});
        end
    end
endmodule

// File: rtl/sqrt_unit_gen.sv
// sqrt_unit_gen: iterative integer square-root peripheral.
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   bus          register bus (slave side): CS/WE/ADDR/DI in, DO/DONE/IRQ out
//   o_dbg_state  control FSM state, for observation only
// Register map:
//   0 W: radicand, starts a computation   R: ROOT (zero-extended)
//   1 W: ignored                          R: REM  (zero-extended)
//   2 W: CTRL {IE, RND} in bits 1..0      R: STATUS {IE, RND, BUSY, DONE}
//   3 reserved, reads 0
// Two radicand bits are consumed per clock, so a result takes WIDTH/2 edges.
// WIDTH must be even and at least 4.
module sqrt_unit_gen
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic                CLK,
    input  logic                RST_N,
    sqrt_unit_gen_if.slave      bus,
    output sqrt_state_e         o_dbg_state
);
    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(H + 1);

    sqrt_state_e      r_state;
    sqrt_state_e      w_state_nxt;

    logic [WIDTH-1:0] r_opnd;     // radicand, shifted left 2 bits per step
    logic [H:0]       r_prem;     // partial remainder
    logic [H-1:0]     r_proot;    // partial root
    logic [CW-1:0]    r_cnt;      // iterations still to do
    logic [H:0]       r_root;     // published root (may be 2^H when rounded)
    logic [H:0]       r_rem;      // published remainder
    logic             r_rnd;
    logic             r_ie;
    logic             r_mode;     // RND as seen at the start of this operation
    logic             r_irq;

    logic             w_start;
    logic             w_ctrl_wr;
    logic             w_last;
    logic             w_busy;
    logic             w_done;
    logic             w_round_up;
    logic [H:0]       w_rem_nxt;
    logic [H-1:0]     w_root_nxt;

    assign w_start   = bus.CS & bus.WE & (bus.ADDR == ADDR_OPERAND);
    assign w_ctrl_wr = bus.CS & bus.WE & (bus.ADDR == ADDR_CTRL);
    assign w_last    = (r_state == ST_BUSY) && (r_cnt == CW'(1));

    sqrt_step #(.H(H)) u_step (
        .i_rem  (r_prem),
        .i_root (r_proot),
        .i_bits (r_opnd[WIDTH-1 -: 2]),
        .o_rem  (w_rem_nxt),
        .o_root (w_root_nxt)
    );

    // Round to nearest: x is closer to (f+1)^2 than f^2 exactly when x - f^2 > f.
    assign w_round_up = r_mode && (w_rem_nxt > {1'b0, w_root_nxt});

    // ---- FSM: state register ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---- FSM: next state ----
    // A start always wins, including on the final iteration edge.
    always_comb begin
        w_state_nxt = r_state;
        if (w_start)     w_state_nxt = ST_BUSY;
        else if (w_last) w_state_nxt = ST_DONE;
    end

    // ---- FSM: outputs ----
    always_comb begin
        w_busy = (r_state == ST_BUSY);
        w_done = (r_state == ST_DONE);
    end

    // ---- control register ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rnd <= 1'b0;
            r_ie  <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_rnd <= bus.DI[0];
            r_ie  <= bus.DI[1];
        end
    end

    // ---- datapath ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_opnd  <= '0;
            r_prem  <= '0;
            r_proot <= '0;
            r_cnt   <= '0;
            r_root  <= '0;
            r_rem   <= '0;
            r_mode  <= 1'b0;
        end else if (w_start) begin
            r_opnd  <= bus.DI;
            r_prem  <= '0;
            r_proot <= '0;
            r_cnt   <= CW'(H);
            r_mode  <= r_rnd;
        end else if (w_busy) begin
            r_opnd  <= r_opnd << 2;
            r_prem  <= w_rem_nxt;
            r_proot <= w_root_nxt;
            r_cnt   <= r_cnt - CW'(1);
            if (w_last) begin
                r_root <= {1'b0, w_root_nxt} + {{H{1'b0}}, w_round_up};
                r_rem  <= w_rem_nxt;
            end
        end
    end

    // ---- completion interrupt ----
    // IE is sampled on the final edge; an aborting start suppresses the pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_irq <= 1'b0;
        else        r_irq <= w_last && !w_start && r_ie;
    end

    // ---- read mux ----
    always_comb begin
        bus.DO = '0;
        case (bus.ADDR)
            ADDR_OPERAND: bus.DO = WIDTH'(r_root);
            ADDR_REM:     bus.DO = WIDTH'(r_rem);
            ADDR_CTRL: begin
                bus.DO[DONE_BIT] = w_done;
                bus.DO[BUSY_BIT] = w_busy;
                bus.DO[RND_BIT]  = r_rnd;
                bus.DO[IE_BIT]   = r_ie;
            end
            default:      bus.DO = '0;
        endcase
    end

    assign bus.DONE    = w_done;
    assign bus.IRQ     = r_irq;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sqrt_unit_gen.sv
module tb_sqrt_unit_gen;
  import sqrt_pkg::*;

  localparam int W = 18;
  localparam int H = W / 2;

  // ---- clock / reset ----
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  sqrt_unit_gen_if #(.WIDTH(W)) bus ();
  sqrt_state_e dbg_state;

  sqrt_unit_gen #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---- scoreboard ----
  logic [W-1:0] exp_root_q[$];
  logic [W-1:0] exp_rem_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] x;
    logic         rnd;
    logic         ie;
    logic [W-1:0] root;
    logic [W-1:0] rem;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // ---- driver tasks ----
  task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge CLK);
    bus.CS = 1'b1;
    bus.WE = 1'b1;
    bus.ADDR = a;
    bus.DI = d;
    @(posedge CLK);
    #1;
    bus.CS = 1'b0;
    bus.WE = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [W-1:0] d);
    bus.ADDR = a;
    #1;
    d = bus.DO;
  endtask

  task automatic set_ctrl(input logic rnd, input logic ie);
    bus_write(ADDR_CTRL, W'({ie, rnd}));
  endtask

  // Write the operand; returns 1 ns after the start edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] r,
                          input logic [W-1:0] m, input bit push);
    logic [W-1:0] st;
    bus_write(ADDR_OPERAND, x);
    if (push) begin
      exp_root_q.push_back(r);
      exp_rem_q.push_back(m);
    end
    check("done_after_start", 32'(bus.DONE), 0);
    check("irq_after_start", 32'(bus.IRQ), 0);
    read_reg(ADDR_CTRL, st);
    check("busy_after_start", 32'(st[BUSY_BIT]), 1);
  endtask

  task automatic wait_done(input bit exp_ie, input logic rnd);
    int n = 0;
    int n_irq = 0;
    int irq_at = 0;
    bit seen = 0;
    logic [W-1:0] v;
    logic [W-1:0] er;
    logic [W-1:0] em;
    while (!seen && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
      if (bus.IRQ) begin
        n_irq++;
        irq_at = n;
      end
      if (bus.DONE) seen = 1;
    end
    check("latency", 32'(n), 32'(H));
    check("irq_count", 32'(n_irq), exp_ie ? 32'd1 : 32'd0);
    if (exp_ie) check("irq_edge", 32'(irq_at), 32'(H));
    if (exp_root_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      er = exp_root_q.pop_front();
      em = exp_rem_q.pop_front();
      read_reg(ADDR_OPERAND, v);
      check("root", 32'(v), 32'(er));
      read_reg(ADDR_REM, v);
      check("rem", 32'(v), 32'(em));
      read_reg(ADDR_CTRL, v);
      check("status_done", 32'(v), 32'(4'b0001 | (4'(rnd) << 2) | (4'(exp_ie) << 3)));
    end
    @(posedge CLK);
    #1;
    check("irq_after_done", 32'(bus.IRQ), 0);
    check("done_held", 32'(bus.DONE), 1);
  endtask

  // ---- test ----
  initial begin
    logic [W-1:0] v;
    logic cur_rnd;
    logic cur_ie;
    bit done_seen;

    bus.CS = 1'b0;
    bus.WE = 1'b0;
    bus.ADDR = 2'd0;
    bus.DI = '0;

    vecs[0] = '{x: 250000, rnd: 0, ie: 0, root: 500, rem: 0};
    vecs[1] = '{x: 1000,   rnd: 0, ie: 0, root: 31,  rem: 39};
    vecs[2] = '{x: 1000,   rnd: 1, ie: 0, root: 32,  rem: 39};
    vecs[3] = '{x: 262143, rnd: 1, ie: 0, root: 512, rem: 1022};
    vecs[4] = '{x: 2500,   rnd: 0, ie: 1, root: 50,  rem: 0};
    vecs[5] = '{x: 0,      rnd: 0, ie: 1, root: 0,   rem: 0};
    vecs[6] = '{x: 16,     rnd: 0, ie: 1, root: 4,   rem: 0};
    vecs[7] = '{x: 25000,  rnd: 0, ie: 1, root: 158, rem: 36};

    // reset state
    #1 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_done", 32'(bus.DONE), 0);
    check("rst_irq", 32'(bus.IRQ), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    read_reg(ADDR_OPERAND, v); check("rst_root", 32'(v), 0);
    read_reg(ADDR_REM, v);     check("rst_rem", 32'(v), 0);
    read_reg(ADDR_CTRL, v);    check("rst_status", 32'(v), 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // table-driven vectors
    cur_rnd = 1'b0;
    cur_ie = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rnd !== cur_rnd || vecs[i].ie !== cur_ie) begin
        set_ctrl(vecs[i].rnd, vecs[i].ie);
        cur_rnd = vecs[i].rnd;
        cur_ie = vecs[i].ie;
      end
      start_op(vecs[i].x, vecs[i].root, vecs[i].rem, 1);
      wait_done(vecs[i].ie, vecs[i].rnd);
    end

    // random operands against the reference model, IE on
    for (int i = 0; i < 6; i++) begin
      int x;
      int r;
      int m;
      logic rnd;
      x = int'($urandom_range(0, 262143));
      rnd = 1'($urandom_range(0, 1));
      r = isqrt(x);
      m = x - r * r;
      set_ctrl(rnd, 1'b1);
      start_op(W'(x), (rnd && m > r) ? W'(r + 1) : W'(r), W'(m), 1);
      wait_done(1'b1, rnd);
    end

    // abort mid-computation: 1000, then 16 four edges later
    set_ctrl(1'b0, 1'b1);
    start_op(W'(1000), '0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("abort_done_low", 32'(bus.DONE), 0);
      check("abort_irq_low", 32'(bus.IRQ), 0);
    end
    start_op(W'(16), W'(4), W'(0), 1);
    wait_done(1'b1, 1'b0);

    // restart on the final iteration edge
    start_op(W'(1000), '0, '0, 0);
    repeat (H - 1) @(posedge CLK);
    start_op(W'(16), W'(4), W'(0), 1);
    wait_done(1'b1, 1'b0);

    // asynchronous reset mid-computation
    start_op(W'(2500), '0, '0, 0);
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("arst_done", 32'(bus.DONE), 0);
    check("arst_irq", 32'(bus.IRQ), 0);
    read_reg(ADDR_OPERAND, v); check("arst_root", 32'(v), 0);
    read_reg(ADDR_REM, v);     check("arst_rem", 32'(v), 0);
    read_reg(ADDR_CTRL, v);    check("arst_status", 32'(v), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK);
      #1;
      if (bus.DONE || bus.IRQ) done_seen = 1;
    end
    check("arst_stays_idle", 32'(done_seen), 0);

    check("scoreboard_drained", 32'(exp_root_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
